// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding, IR half-select constants and a state classification helper.
package fetch_sequencer_pkg;

    // FSM state encoding (3-bit, kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ_LO = 3'd1;
    localparam logic [2:0] ST_WR_LO  = 3'd2;
    localparam logic [2:0] ST_REQ_HI = 3'd3;
    localparam logic [2:0] ST_WR_HI  = 3'd4;
    localparam logic [2:0] ST_VALID  = 3'd5;

    // IR byte-write half select
    localparam logic IR_LH_LOW  = 1'b0;
    localparam logic IR_LH_HIGH = 1'b1;

    // True in the two states that hold a memory request open
    function automatic logic is_req_state(input logic [2:0] st);
        return (st == ST_REQ_LO) || (st == ST_REQ_HI);
    endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: ADDR_W register with synchronous load and increment.
// Increment wraps modulo 2^ADDR_W; load has priority over increment.
module program_counter #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_value_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: jump target, wrapped increment, or hold
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_value_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register, asynchronously reset to RESET_PC
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads a 16-bit instruction as two bytes
// (low then high) over a req/ack memory handshake, writes each byte into
// the IR, flags InstrValid and waits for the decoder. Requests that see no
// MemAck within ACK_TIMEOUT cycles abort to IDLE and set a sticky FetchErr.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                ACK_TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [7:0]        MemData,
    input  logic              MemAck,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        IR_Byte,
    output logic              IR_Write,
    output logic              IR_LH,
    output logic              InstrValid,
    input  logic              DecodeDone,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCLoadValue,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              FetchErr
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    // Last count value still allowed to wait; an unanswered cycle here aborts
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [2:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [7:0]        ir_byte_q,   ir_byte_d;
    logic              fetch_err_q, fetch_err_d;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk          (Clock),
        .rst_n        (Reset_n),
        .load_i       (pc_load),
        .load_value_i (PCLoadValue),
        .inc_i        (pc_inc),
        .pc_o         (pc)
    );

    // FSM transitions, timeout counting, byte capture and PC control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ir_byte_d   = ir_byte_q;
        fetch_err_d = fetch_err_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A jump on the Start edge is used by the fetch it launches
                pc_load = PCLoad;
                if (Start) begin
                    state_d = ST_REQ_LO;
                end
            end
            ST_REQ_LO, ST_REQ_HI: begin
                if (MemAck) begin
                    ir_byte_d = MemData;
                    pc_inc    = 1'b1;
                    cnt_d     = '0;
                    state_d   = (state_q == ST_REQ_LO) ? ST_WR_LO : ST_WR_HI;
                end else if (cnt_q == CNT_LAST) begin
                    // PC is left alone so the same byte is refetched next time
                    fetch_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_LO: state_d = ST_REQ_HI;
            ST_WR_HI: state_d = ST_VALID;
            ST_VALID: begin
                if (DecodeDone) begin
                    // Jump overrides the PC already advanced past this instruction
                    pc_load = PCLoad;
                    state_d = Start ? ST_REQ_LO : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, timeout counter, IR byte and sticky error registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ir_byte_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ir_byte_q   <= ir_byte_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Moore outputs decoded from state
    assign MemReq     = is_req_state(state_q);
    assign MemAddr    = MemReq ? pc : '0;
    assign IR_Byte    = ir_byte_q;
    assign IR_Write   = (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
    assign IR_LH      = (state_q == ST_WR_HI) ? IR_LH_HIGH : IR_LH_LOW;
    assign InstrValid = (state_q == ST_VALID);
    assign Busy       = (state_q != ST_IDLE);
    assign FetchErr   = fetch_err_q;
    assign PC         = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. Stimulus computes the expected
// sequence of bus requests, IR writes, completed instructions and aborts
// from a byte-array memory and a model PC, and queues them; a monitor pops
// and compares whenever the DUT shows the corresponding output.
module tb_fetch_sequencer;

    localparam int TO = 15;

    typedef enum logic [1:0] {EV_REQ, EV_WR, EV_VALID, EV_ABORT} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        lh;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Start = 1'b0, MemAck = 1'b0, DecodeDone = 1'b0, PCLoad = 1'b0;
    logic [7:0]  MemData = '0;
    logic [15:0] PCLoadValue = '0;
    logic        MemReq, IR_Write, IR_LH, InstrValid, Busy, FetchErr;
    logic [15:0] MemAddr, PC;
    logic [7:0]  IR_Byte;

    logic [7:0]  mem [0:65535];
    logic [15:0] m_pc;
    exp_t        exp_q[$];
    int          plan_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .ACK_TIMEOUT(TO)) dut (
        .Clock(clk), .Reset_n(Reset_n), .Start(Start), .MemData(MemData),
        .MemAck(MemAck), .MemReq(MemReq), .MemAddr(MemAddr), .IR_Byte(IR_Byte),
        .IR_Write(IR_Write), .IR_LH(IR_LH), .InstrValid(InstrValid),
        .DecodeDone(DecodeDone), .PCLoad(PCLoad), .PCLoadValue(PCLoadValue),
        .PC(PC), .Busy(Busy), .FetchErr(FetchErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_exp(input ev_kind_t want, output exp_t e);
        check("sb_has_entry", exp_q.size() != 0, 1'b1);
        e = '0;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_kind", e.kind, want);
        end
    endtask

    // Expected events for one fetch starting on edge s; negative wait = no ack
    task automatic push_fetch(input int wlo, input int whi, input int s);
        logic [15:0] a1;
        plan_q.push_back(wlo);
        exp_q.push_back('{kind: EV_REQ, addr: m_pc, default: '0});
        if (wlo < 0) begin
            exp_q.push_back('{kind: EV_ABORT, cyc: s + TO, default: '0});
            return;
        end
        exp_q.push_back('{kind: EV_WR, data: mem[m_pc], lh: 1'b0, default: '0});
        a1 = m_pc + 16'd1;
        plan_q.push_back(whi);
        exp_q.push_back('{kind: EV_REQ, addr: a1, default: '0});
        if (whi < 0) begin
            exp_q.push_back('{kind: EV_ABORT, cyc: s + wlo + 2 + TO, default: '0});
            m_pc = a1;
            return;
        end
        exp_q.push_back('{kind: EV_WR, data: mem[a1], lh: 1'b1, default: '0});
        exp_q.push_back('{kind: EV_VALID, instr: {mem[a1], mem[m_pc]}, pc: a1 + 16'd1,
                          cyc: s + wlo + whi + 4, default: '0});
        m_pc = a1 + 16'd1;
    endtask

    task automatic quiet_inputs();
        Start = 1'b0; PCLoad = 1'b0; DecodeDone = 1'b0; PCLoadValue = 16'($urandom);
    endtask

    task automatic noise_inputs();
        Start = 1'($urandom); PCLoad = 1'($urandom);
        DecodeDone = 1'($urandom); PCLoadValue = 16'($urandom);
    endtask

    task automatic start_from_idle(input bit ld, input logic [15:0] lv, input int wlo, input int whi);
        @(negedge clk); #1;
        Start = 1'b1; PCLoad = ld; PCLoadValue = lv; DecodeDone = 1'b0;
        if (ld) m_pc = lv;
        push_fetch(wlo, whi, cyc + 1);
        @(posedge clk); #1;
        quiet_inputs();
    endtask

    task automatic finish_decode(input int dd, input bit nstart, input bit ld,
                                 input logic [15:0] lv, input int wlo, input int whi);
        repeat (dd) begin
            @(negedge clk); #1;
            Start = 1'($urandom);
        end
        @(negedge clk); #1;
        DecodeDone = 1'b1; Start = nstart; PCLoad = ld; PCLoadValue = lv;
        if (ld) m_pc = lv;
        if (nstart) push_fetch(wlo, whi, cyc + 1);
        @(posedge clk); #1;
        quiet_inputs();
    endtask

    task automatic wait_valid();
        for (int n = 0; n <= 200; n++) begin
            @(negedge clk); #1;
            if (InstrValid) begin
                quiet_inputs();
                return;
            end
            noise_inputs();
        end
        quiet_inputs();
        check("wait_valid_timeout", InstrValid, 1'b1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n <= 200; n++) begin
            @(negedge clk); #1;
            if (!Busy) begin
                quiet_inputs();
                return;
            end
            noise_inputs();
        end
        quiet_inputs();
        check("wait_idle_timeout", Busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_memreq"}, MemReq, 1'b0);
        check({tag, "_memaddr"}, MemAddr, 16'h0000);
        check({tag, "_ir_byte"}, IR_Byte, 8'h00);
        check({tag, "_ir_write"}, IR_Write, 1'b0);
        check({tag, "_ir_lh"}, IR_LH, 1'b0);
        check({tag, "_instr_valid"}, InstrValid, 1'b0);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_fetch_err"}, FetchErr, 1'b0);
        check({tag, "_pc"}, PC, 16'h0000);
    endtask

    // Memory model: acks after a planned number of wait cycles, never if negative
    initial begin : responder
        bit in_req = 1'b0;
        int w = 0;
        int cnt = 0;
        forever begin
            @(negedge clk); #1;
            MemAck  = 1'b0;
            MemData = 8'($urandom);
            if (MemReq && Reset_n) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    cnt    = 0;
                    w      = (plan_q.size() != 0) ? plan_q.pop_front() : 0;
                end
                if (w >= 0 && cnt == w) begin
                    MemAck  = 1'b1;
                    MemData = mem[MemAddr];
                    in_req  = 1'b0;
                end else begin
                    cnt++;
                end
            end else begin
                in_req = 1'b0;
                MemAck = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: compare every visible DUT event against the head of the queue
    initial begin : monitor
        bit          req_active = 1'b0;
        bit          prev_valid = 1'b0;
        logic [15:0] cur_addr = '0;
        logic [15:0] ir_act = '0;
        exp_t        e;
        forever begin
            @(negedge clk); #2;
            if (!Reset_n) begin
                req_active = 1'b0;
                prev_valid = 1'b0;
                continue;
            end
            if (req_active && !MemReq) begin
                pop_exp(EV_ABORT, e);
                check("abort_cycle", cyc, e.cyc);
                check("abort_fetch_err", FetchErr, 1'b1);
                req_active = 1'b0;
            end
            if (MemReq) begin
                if (!req_active) begin
                    pop_exp(EV_REQ, e);
                    check("req_addr", MemAddr, e.addr);
                    cur_addr   = e.addr;
                    req_active = 1'b1;
                end else begin
                    check("req_addr_hold", MemAddr, cur_addr);
                end
                if (MemAck) req_active = 1'b0;
            end
            if (IR_Write) begin
                pop_exp(EV_WR, e);
                check("ir_byte", IR_Byte, e.data);
                check("ir_lh", IR_LH, e.lh);
                if (IR_LH) ir_act[15:8] = IR_Byte;
                else       ir_act[7:0]  = IR_Byte;
            end
            if (InstrValid && !prev_valid) begin
                pop_exp(EV_VALID, e);
                check("ir_out", ir_act, e.instr);
                check("valid_pc", PC, e.pc);
                check("valid_cycle", cyc, e.cyc);
            end
            prev_valid = InstrValid;
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        m_pc = 16'h0000;

        // Asynchronous reset before any clock edge
        #2 Reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        #1 Reset_n = 1'b1;

        // Jump in IDLE on the Start edge, zero-wait memory
        mem[16'h0040] = 8'h34;
        mem[16'h0041] = 8'h12;
        start_from_idle(1'b1, 16'h0040, 0, 0);
        wait_valid();
        finish_decode(1, 1'b0, 1'b0, 16'h0, 0, 0);
        check("t1_busy_after", Busy, 1'b0);

        // Two wait cycles per byte, then back-to-back fetch with a jump to 0100
        start_from_idle(1'b0, 16'h0, 2, 2);
        wait_valid();
        finish_decode(2, 1'b1, 1'b1, 16'h0100, 0, 1);
        wait_valid();
        finish_decode(0, 1'b0, 1'b0, 16'h0, 0, 0);
        check("t4_busy_idle", Busy, 1'b0);

        // PC wrap across FFFF
        start_from_idle(1'b1, 16'hFFFF, 1, 0);
        wait_valid();
        finish_decode(0, 1'b0, 1'b0, 16'h0, 0, 0);
        check("t3_pc_wrapped", PC, 16'h0001);

        // Timeout on the high byte, then on the low byte
        start_from_idle(1'b1, 16'h2000, 0, -1);
        wait_idle();
        check("t5_fetch_err", FetchErr, 1'b1);
        check("t5_pc", PC, 16'h2001);
        start_from_idle(1'b0, 16'h0, -1, 0);
        wait_idle();
        check("t5_lo_pc", PC, m_pc);

        // Randomized sequence of fetches, jumps, back-to-back runs and timeouts
        begin
            bit in_valid = 1'b0;
            for (int i = 0; i < 24; i++) begin
                int          wlo = $urandom_range(0, 3);
                int          whi = $urandom_range(0, 3);
                bit          ld  = 1'($urandom);
                logic [15:0] lv  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                bit          tmo = ($urandom_range(0, 7) == 0);
                if (tmo) begin
                    if ($urandom_range(0, 1) == 0) wlo = -1;
                    else                           whi = -1;
                end
                if (in_valid) finish_decode($urandom_range(0, 2), 1'b1, ld, lv, wlo, whi);
                else          start_from_idle(ld, lv, wlo, whi);
                if (tmo) begin
                    wait_idle();
                    check("rand_err_pc", PC, m_pc);
                    in_valid = 1'b0;
                end else begin
                    wait_valid();
                    in_valid = 1'b1;
                end
            end
            if (in_valid) finish_decode(0, 1'b0, 1'b0, 16'h0, 0, 0);
            check("rand_busy_idle", Busy, 1'b0);
        end

        // Reset in the middle of a high-byte wait, no clock edge needed
        start_from_idle(1'b1, 16'h0300, 1, -1);
        for (int n = 0; n < 50 && exp_q.size() > 1; n++) @(negedge clk);
        check("t6_reached_req_hi", exp_q.size(), 1);
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        Reset_n = 1'b0;
        #1 check_all_zero("t6");
        m_pc = 16'h0000;
        repeat (2) @(negedge clk);
        #1 Reset_n = 1'b1;

        // Clean fetch after reset
        start_from_idle(1'b0, 16'h0, 0, 0);
        wait_valid();
        finish_decode(0, 1'b0, 1'b0, 16'h0, 0, 0);
        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("final_fetch_err_clear", FetchErr, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
